mac_seq_divider: RTL and testbench



---
 rtl/mac_seq_divider_if.sv | 25 ++
 rtl/mac_seq_divider.sv | 104 ++++++++++
 tb/tb_mac_seq_divider.sv | 249 ++++++++++++++++++++++++
 3 files changed

// File: rtl/mac_seq_divider_if.sv
// Start/busy/done handshake bundle for mac_seq_divider.
// master drives the request and operands; slave returns status and results.
interface mac_seq_divider_if;
  localparam int unsigned DW = 8;
  localparam int unsigned VW = 4;

  logic          start;
  logic [DW-1:0] dividend;
  logic [VW-1:0] divisor;
  logic          busy;
  logic          done;
  logic [DW-1:0] quotient;
  logic [VW-1:0] remainder;
  logic          div_by_zero;

  modport master (
    output start, dividend, divisor,
    input  busy, done, quotient, remainder, div_by_zero
  );

  modport slave (
    input  start, dividend, divisor,
    output busy, done, quotient, remainder, div_by_zero
  );
endinterface

// File: rtl/mac_seq_divider.sv
// Sequential 8-by-4 restoring divider, one quotient bit per clock, MSB first.
// Optional feature macro: MAC_DIV_ZERO_CHECK_EN -- when defined, a zero divisor
// skips the iteration, completes one cycle after acceptance and raises div_by_zero.
module mac_seq_divider (
  input  logic              clk,
  input  logic              rst,
  mac_seq_divider_if.slave  bus
);
  localparam int unsigned DW = 8;
  localparam int unsigned VW = 4;
  localparam int unsigned CW = 3;

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t        state;
  logic [DW-1:0] dvd;           // dividend shifts out the top, quotient bits shift in the bottom
  logic [VW-1:0] dvs;
  logic [VW-1:0] pr;            // partial remainder; its fifth bit is always dropped by the shift
  logic [CW-1:0] cnt;

  logic          busy_reg;
  logic          done_reg;
  logic [DW-1:0] quotient_reg;
  logic [VW-1:0] remainder_reg;
  logic          dbz_reg;

  logic [VW:0]   pr_shift_c;
  logic          q_bit_c;
  logic [VW-1:0] pr_next_c;
  logic          zero_abort_c;

  // One restoring step: shift in next dividend bit, trial-subtract, restore on borrow
  always_comb begin
    pr_shift_c = {pr, dvd[DW-1]};
    q_bit_c    = (pr_shift_c >= {1'b0, dvs});
    pr_next_c  = q_bit_c ? VW'(pr_shift_c - {1'b0, dvs}) : pr_shift_c[VW-1:0];
  end

`ifdef MAC_DIV_ZERO_CHECK_EN
  assign zero_abort_c = (dvs == '0);
`else
  assign zero_abort_c = 1'b0;
`endif

  // Control FSM, datapath registers and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      dvd           <= '0;
      dvs           <= '0;
      pr            <= '0;
      cnt           <= '0;
      busy_reg      <= 1'b0;
      done_reg      <= 1'b0;
      quotient_reg  <= '0;
      remainder_reg <= '0;
      dbz_reg       <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            dvd      <= bus.dividend;
            dvs      <= bus.divisor;
            pr       <= '0;
            cnt      <= '0;
            busy_reg <= 1'b1;
            state    <= CALC;
          end
        end
        CALC: begin
          if (zero_abort_c) begin
            quotient_reg  <= '1;
            remainder_reg <= dvd[VW-1:0];
            dbz_reg       <= 1'b1;
            busy_reg      <= 1'b0;
            done_reg      <= 1'b1;
            state         <= DONE;
          end else begin
            dvd <= {dvd[DW-2:0], q_bit_c};
            pr  <= pr_next_c;
            cnt <= cnt + CW'(1);
            if (cnt == CW'(DW-1)) begin
              quotient_reg  <= {dvd[DW-2:0], q_bit_c};
              remainder_reg <= pr_next_c;
              dbz_reg       <= 1'b0;
              busy_reg      <= 1'b0;
              done_reg      <= 1'b1;
              state         <= DONE;
            end
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.busy        = busy_reg;
  assign bus.done        = done_reg;
  assign bus.quotient    = quotient_reg;
  assign bus.remainder   = remainder_reg;
  assign bus.div_by_zero = dbz_reg;
endmodule

// File: tb/tb_mac_seq_divider.sv
// Self-checking bench for mac_seq_divider: arithmetic reference model checked
// every cycle, plus directed operations with hand-computed results.
module tb_mac_seq_divider;
  logic clk = 1'b0;
  logic rst = 1'b1;

  mac_seq_divider_if bus ();

  mac_seq_divider dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int fails  = 0;

`ifdef MAC_DIV_ZERO_CHECK_EN
  localparam int ZERO_LAT = 1;
  localparam int ZERO_FLAG = 1;
`else
  localparam int ZERO_LAT = 8;
  localparam int ZERO_FLAG = 0;
`endif

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: results from plain division, timing from edge arithmetic
  int edge_n      = 0;
  int m_acc       = -100;
  int m_done_edge = -100;
  int m_free      = 0;
  int m_q = 0, m_r = 0, m_z = 0;
  int p_q = 0, p_r = 0, p_z = 0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_acc = -100; m_done_edge = -100; m_free = 0;
      m_q = 0; m_r = 0; m_z = 0;
    end else begin
      edge_n++;
      if (edge_n == m_done_edge) begin
        m_q = p_q; m_r = p_r; m_z = p_z;
      end
      if (edge_n >= m_free && bus.start) begin
        int a, b;
        a = int'(bus.dividend);
        b = int'(bus.divisor);
        m_acc = edge_n;
        if (b == 0) begin
          p_q = 255; p_r = a % 16; p_z = ZERO_FLAG;
          m_done_edge = edge_n + ZERO_LAT;
        end else begin
          p_q = a / b; p_r = a % b; p_z = 0;
          m_done_edge = edge_n + 8;
        end
        m_free = m_done_edge + 2;
      end
    end
  end

  // Every-cycle comparison against the model
  always @(negedge clk) begin
    int eb, ed;
    eb = (edge_n >= m_acc && edge_n < m_done_edge) ? 1 : 0;
    ed = (edge_n == m_done_edge && !rst) ? 1 : 0;
    check("busy", int'(bus.busy), eb);
    check("done", int'(bus.done), ed);
    check("quotient", int'(bus.quotient), m_q);
    check("remainder", int'(bus.remainder), m_r);
    check("div_by_zero", int'(bus.div_by_zero), m_z);
    check("busy_and_done", int'(bus.busy && bus.done), 0);
  end

  // Issue one operation from an idle DUT; caller sits just after a rising edge
  task automatic run_op(input int a, input int b, input int eq, input int er,
                        input int elat, input int ez);
    int n, bcnt;
    bit seen;
    bus.start    = 1'b1;
    bus.dividend = 8'(a);
    bus.divisor  = 4'(b);
    @(posedge clk);
    #1;
    bus.start    = 1'b0;
    bus.dividend = 8'(a ^ 8'h5A);
    bus.divisor  = 4'(b ^ 4'h3);
    bcnt = 0;
    seen = 1'b0;
    @(negedge clk);
    if (bus.busy) bcnt++;
    for (n = 1; n <= 20; n++) begin
      @(posedge clk);
      @(negedge clk);
      if (bus.busy) bcnt++;
      if (bus.done) begin
        seen = 1'b1;
        break;
      end
    end
    check("done_seen", int'(seen), 1);
    if (seen) begin
      check("latency", n, elat);
      check("busy_cycles", bcnt, elat);
      check("op_quotient", int'(bus.quotient), eq);
      check("op_remainder", int'(bus.remainder), er);
      check("op_flag", int'(bus.div_by_zero), ez);
    end
    @(posedge clk);
    #1;
  endtask

  int qexp[3] = '{17, 255, 0};
  int rexp[3] = '{0, 0, 5};
  int aops[3] = '{255, 255, 5};
  int bops[3] = '{15, 1, 9};

  initial begin
    int dcnt;
    bus.start = 1'b0;
    bus.dividend = '0;
    bus.divisor = '0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    check("rst_busy", int'(bus.busy), 0);
    check("rst_done", int'(bus.done), 0);
    check("rst_quotient", int'(bus.quotient), 0);
    check("rst_remainder", int'(bus.remainder), 0);
    @(posedge clk);
    #1;

    run_op(200, 7, 28, 4, 8, 0);

    // Back-to-back with start held high
    bus.start = 1'b1;
    bus.dividend = 8'(aops[0]);
    bus.divisor = 4'(bops[0]);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      if (i < 2) begin
        bus.dividend = 8'(aops[i+1]);
        bus.divisor = 4'(bops[i+1]);
      end else begin
        bus.start = 1'b0;
      end
      repeat (8) @(posedge clk);
      #1;
      check("b2b_done", int'(bus.done), 1);
      check("b2b_quotient", int'(bus.quotient), qexp[i]);
      check("b2b_remainder", int'(bus.remainder), rexp[i]);
      @(posedge clk);
      #1;
    end

    // start during CALC and DONE must be ignored
    bus.start = 1'b1;
    bus.dividend = 8'd200;
    bus.divisor = 4'd7;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    bus.start = 1'b1;
    bus.dividend = 8'd13;
    bus.divisor = 4'd2;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    check("ign_done", int'(bus.done), 1);
    check("ign_quotient", int'(bus.quotient), 28);
    check("ign_remainder", int'(bus.remainder), 4);
    bus.start = 1'b1;
    bus.dividend = 8'd99;
    bus.divisor = 4'd3;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    @(posedge clk);
    #1;
    check("ign_not_accepted", int'(bus.busy), 0);

    run_op(100, 0, 255, 4, ZERO_LAT, ZERO_FLAG);

    // Reset during step 4 aborts the operation
    bus.start = 1'b1;
    bus.dividend = 8'd200;
    bus.divisor = 4'd7;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    check("abort_busy", int'(bus.busy), 0);
    check("abort_done", int'(bus.done), 0);
    check("abort_quotient", int'(bus.quotient), 0);
    check("abort_remainder", int'(bus.remainder), 0);
    check("abort_flag", int'(bus.div_by_zero), 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    dcnt = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (bus.done) dcnt++;
    end
    check("abort_no_done", dcnt, 0);
    @(posedge clk);
    #1;
    run_op(50, 3, 16, 2, 8, 0);

    // Full sweep of nonzero-divisor operand pairs, checked by the model
    bus.start = 1'b1;
    for (int a = 0; a < 256; a++) begin
      for (int b = 1; b < 16; b++) begin
        bus.dividend = 8'(a);
        bus.divisor = 4'(b);
        repeat (10) @(posedge clk);
        #1;
      end
    end
    bus.start = 1'b0;
    repeat (12) @(posedge clk);
    #1;

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not complete, checks %0d failures %0d", checks, fails);
    $fatal(1, "timeout");
  end
endmodule
